// File: rtl/iis_dma_ctrl.sv
// Memory-side DMA sequencer for the I2S FIFOs: round-robin tx/rx frames over one memory port.
// Latency: grant to tx fill in 4 cycles at zero-wait ack; mem_req holds until ack, IDLE waits on FIFO full/empty.
module iis_dma_ctrl #(
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          tx_start,
  input  logic          tx_circ,
  input  logic [AW-1:0] tx_base,
  input  logic [LW-1:0] tx_len,
  input  logic          rx_start,
  input  logic          rx_circ,
  input  logic [AW-1:0] rx_base,
  input  logic [LW-1:0] rx_len,
  input  logic          tx_data_l_full,
  input  logic          tx_data_r_full,
  output logic          tx_data_fill,
  output logic [31:0]   tx_data_l,
  output logic [31:0]   tx_data_r,
  input  logic          rx_data_l_empty,
  input  logic          rx_data_r_empty,
  output logic          rx_data_drain,
  input  logic [31:0]   rx_data_l,
  input  logic [31:0]   rx_data_r,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          tx_done,
  output logic          rx_done,
  output logic          tx_wrap,
  output logic          rx_wrap
);

  typedef enum logic [2:0] {
    IDLE, TX_RD_L, TX_RD_R, TX_PUSH, RX_POP, RX_WR_L, RX_WR_R, SETTLE
  } state_t;

  state_t        state, state_nxt;
  logic          last_rx;
  logic [LW-1:0] tx_rem, rx_rem;
  logic [AW-1:0] tx_addr, rx_addr;
  logic          tx_pend, rx_pend;
  logic [AW-1:0] tx_pbase, rx_pbase;
  logic [LW-1:0] tx_plen, rx_plen;
  logic [31:0]   rx_hold_l, rx_hold_r;
  logic          tx_need, rx_need, grant_tx, grant_rx;
  logic          tx_busy, rx_busy, tx_load_now, rx_load_now;

  assign tx_need = (tx_rem != '0) && !tx_data_l_full && !tx_data_r_full;
  assign rx_need = (rx_rem != '0) && !rx_data_l_empty && !rx_data_r_empty;

  // SETTLE belongs to whichever channel was granted last
  assign tx_busy = (state inside {TX_RD_L, TX_RD_R, TX_PUSH}) || (state == SETTLE && !last_rx);
  assign rx_busy = (state inside {RX_POP, RX_WR_L, RX_WR_R}) || (state == SETTLE && last_rx);

  // A start landing in the channel's own SETTLE is applied on this same IDLE entry
  assign tx_load_now = tx_start && (!tx_busy || state == SETTLE);
  assign rx_load_now = rx_start && (!rx_busy || state == SETTLE);

  always_comb begin
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    if (state == IDLE && enable) begin
      if (tx_need && rx_need) begin
        grant_tx = last_rx;
        grant_rx = !last_rx;
      end else begin
        grant_tx = tx_need;
        grant_rx = rx_need;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    tx_data_fill  = 1'b0;
    rx_data_drain = 1'b0;
    case (state)
      IDLE: begin
        if (grant_tx)      state_nxt = TX_RD_L;
        else if (grant_rx) state_nxt = RX_POP;
      end
      TX_RD_L: begin
        mem_req  = 1'b1;
        mem_addr = tx_addr;
        if (mem_ack) state_nxt = enable ? TX_RD_R : SETTLE;
      end
      TX_RD_R: begin
        mem_req  = 1'b1;
        mem_addr = tx_addr + AW'(4);
        if (mem_ack) state_nxt = enable ? TX_PUSH : SETTLE;
      end
      // once the push is issued the frame is committed, even if enable drops
      TX_PUSH: begin
        tx_data_fill = 1'b1;
        state_nxt    = SETTLE;
      end
      RX_POP: begin
        rx_data_drain = 1'b1;
        state_nxt     = RX_WR_L;
      end
      RX_WR_L: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = rx_addr;
        mem_wdata = rx_hold_l;
        if (mem_ack) state_nxt = RX_WR_R;
      end
      RX_WR_R: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = rx_addr + AW'(4);
        mem_wdata = rx_hold_r;
        if (mem_ack) state_nxt = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_rx   <= 1'b1;
      tx_rem    <= '0;
      rx_rem    <= '0;
      tx_addr   <= '0;
      rx_addr   <= '0;
      tx_pend   <= 1'b0;
      rx_pend   <= 1'b0;
      tx_pbase  <= '0;
      rx_pbase  <= '0;
      tx_plen   <= '0;
      rx_plen   <= '0;
      rx_hold_l <= '0;
      rx_hold_r <= '0;
      tx_data_l <= '0;
      tx_data_r <= '0;
      tx_done   <= 1'b0;
      rx_done   <= 1'b0;
      tx_wrap   <= 1'b0;
      rx_wrap   <= 1'b0;
    end else begin
      tx_wrap <= 1'b0;
      rx_wrap <= 1'b0;
      if (grant_tx)      last_rx <= 1'b0;
      else if (grant_rx) last_rx <= 1'b1;

      if (state == TX_RD_L && mem_ack) tx_data_l <= mem_rdata;
      if (state == TX_RD_R && mem_ack) tx_data_r <= mem_rdata;
      if (state == RX_POP) begin
        rx_hold_l <= rx_data_l;
        rx_hold_r <= rx_data_r;
      end

      if (tx_start && !tx_load_now) begin
        tx_pend  <= 1'b1;
        tx_pbase <= tx_base;
        tx_plen  <= tx_len;
      end
      if (tx_load_now) begin
        tx_addr <= tx_base;
        tx_rem  <= tx_len;
        tx_done <= (tx_len == '0) && !tx_circ;
        tx_pend <= 1'b0;
      end else if (tx_pend && tx_busy && state == SETTLE) begin
        tx_addr <= tx_pbase;
        tx_rem  <= tx_plen;
        tx_done <= (tx_plen == '0) && !tx_circ;
        tx_pend <= 1'b0;
      end else if (state == TX_PUSH) begin
        if (tx_rem == LW'(1) && tx_circ) begin
          tx_addr <= tx_base;
          tx_rem  <= tx_len;
          tx_wrap <= 1'b1;
        end else begin
          tx_addr <= tx_addr + AW'(8);
          tx_rem  <= tx_rem - LW'(1);
          if (tx_rem == LW'(1)) tx_done <= 1'b1;
        end
      end

      if (rx_start && !rx_load_now) begin
        rx_pend  <= 1'b1;
        rx_pbase <= rx_base;
        rx_plen  <= rx_len;
      end
      if (rx_load_now) begin
        rx_addr <= rx_base;
        rx_rem  <= rx_len;
        rx_done <= (rx_len == '0) && !rx_circ;
        rx_pend <= 1'b0;
      end else if (rx_pend && rx_busy && state == SETTLE) begin
        rx_addr <= rx_pbase;
        rx_rem  <= rx_plen;
        rx_done <= (rx_plen == '0) && !rx_circ;
        rx_pend <= 1'b0;
      end else if (state == RX_WR_R && mem_ack) begin
        if (rx_rem == LW'(1) && rx_circ) begin
          rx_addr <= rx_base;
          rx_rem  <= rx_len;
          rx_wrap <= 1'b1;
        end else begin
          rx_addr <= rx_addr + AW'(8);
          rx_rem  <= rx_rem - LW'(1);
          if (rx_rem == LW'(1)) rx_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iis_dma_ctrl.sv
// Bench for iis_dma_ctrl: memory slave with random waits, FIFO models and a buffer-level reference.
module tb_iis_dma_ctrl;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0, rstn = 1'b0, enable = 1'b0;
  logic          tx_start = 1'b0, tx_circ = 1'b0, rx_start = 1'b0, rx_circ = 1'b0;
  logic [AW-1:0] tx_base = '0, rx_base = '0;
  logic [LW-1:0] tx_len = '0, rx_len = '0;
  logic          tx_full = 1'b0;
  logic          tx_data_fill, rx_data_drain;
  logic [31:0]   tx_data_l, tx_data_r;
  logic          rx_data_l_empty = 1'b1, rx_data_r_empty = 1'b1;
  logic [31:0]   rx_data_l = '0, rx_data_r = '0;
  logic          mem_req, mem_we, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = '0;
  logic          tx_done, rx_done, tx_wrap, rx_wrap;

  iis_dma_ctrl #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .tx_start(tx_start), .tx_circ(tx_circ), .tx_base(tx_base), .tx_len(tx_len),
    .rx_start(rx_start), .rx_circ(rx_circ), .rx_base(rx_base), .rx_len(rx_len),
    .tx_data_l_full(tx_full), .tx_data_r_full(tx_full),
    .tx_data_fill(tx_data_fill), .tx_data_l(tx_data_l), .tx_data_r(tx_data_r),
    .rx_data_l_empty(rx_data_l_empty), .rx_data_r_empty(rx_data_r_empty),
    .rx_data_drain(rx_data_drain), .rx_data_l(rx_data_l), .rx_data_r(rx_data_r),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .tx_done(tx_done), .rx_done(rx_done), .tx_wrap(tx_wrap), .rx_wrap(rx_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } beat_t;
  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] mem [logic [31:0]];
  beat_t       beats[$];
  pair_t       tx_got[$];
  pair_t       rxq[$];
  pair_t       exp_rx[$];
  int          fill_cyc[$];
  int          grants[$];
  int          wait_plan[$];
  int          tx_wraps = 0, drains = 0, max_wait = 0, wait_left = 0, n = 0;
  bit          in_beat = 0, pop_pend = 0, prev_pend = 0;
  logic [64:0] prev_req = '0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // memory slave, FIFO models and event logging, all on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (prev_pend && rstn)
      check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, prev_req});
    prev_pend = 0;
    if (!rstn) begin
      mem_ack = 1'b0;
      in_beat = 0;
    end else if (mem_req) begin
      if (!in_beat) begin
        in_beat   = 1;
        wait_left = (wait_plan.size() != 0) ? wait_plan.pop_front() : int'($urandom_range(0, max_wait));
      end
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        in_beat   = 0;
        mem_rdata = mem_we ? 32'h0 : rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        beats.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : mem_rdata), cyc: cyc});
      end else begin
        wait_left--;
        mem_ack   = 1'b0;
        prev_pend = 1;
        prev_req  = {mem_we, mem_addr, mem_wdata};
      end
    end else begin
      mem_ack = 1'b0;
    end
    if (tx_data_fill) begin
      tx_got.push_back('{l: tx_data_l, r: tx_data_r});
      fill_cyc.push_back(cyc);
      grants.push_back(0);
    end
    if (rx_data_drain) begin
      drains++;
      grants.push_back(1);
    end
    if (tx_wrap) tx_wraps++;
    if (pop_pend && rxq.size() != 0) void'(rxq.pop_front());
    pop_pend        = rx_data_drain;
    rx_data_l_empty = (rxq.size() == 0);
    rx_data_r_empty = (rxq.size() == 0);
    rx_data_l       = (rxq.size() != 0) ? rxq[0].l : 32'h0;
    rx_data_r       = (rxq.size() != 0) ? rxq[0].r : 32'h0;
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete(); tx_got.delete(); fill_cyc.delete(); grants.delete(); exp_rx.delete();
    wait_plan.delete();
    tx_wraps = 0; drains = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
    clear_logs();
  endtask

  task automatic start_tx(input logic [31:0] b, input logic [15:0] l, input logic c);
    tx_base = b; tx_len = l; tx_circ = c; tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
  endtask

  task automatic start_rx(input logic [31:0] b, input logic [15:0] l, input logic c);
    rx_base = b; rx_len = l; rx_circ = c; rx_start = 1'b1;
    step(1);
    rx_start = 1'b0;
  endtask

  task automatic wait_flag(input string tag, input int which, input int budget);
    int k = 0;
    while (k < budget && !((which == 0) ? tx_done : rx_done)) begin
      step(1);
      k++;
    end
    check(tag, (which == 0) ? tx_done : rx_done, 1);
  endtask

  task automatic push_rx(input int cnt);
    pair_t p;
    for (int i = 0; i < cnt; i++) begin
      p = '{l: $urandom, r: $urandom};
      rxq.push_back(p);
      exp_rx.push_back(p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    step(3);
    check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, tx_data_fill, tx_data_l, tx_data_r,
                            rx_data_drain, tx_done, rx_done, tx_wrap, rx_wrap}, '0);
    rstn = 1'b1; enable = 1'b1;
    step(2);

    // zero-length linear buffer: done at once, no traffic
    clear_logs();
    start_tx(32'h500, 16'd0, 1'b0);
    check("len0_done", tx_done, 1);
    step(5);
    check("len0_nbeats", beats.size(), 0);

    // linear tx, two frames, zero-wait memory
    clear_logs();
    mem[32'h100] = 32'hA0; mem[32'h104] = 32'hB0; mem[32'h108] = 32'hA1; mem[32'h10C] = 32'hB1;
    start_tx(32'h100, 16'd2, 1'b0);
    check("a_done_clr", tx_done, 0);
    wait_flag("a_done", 0, 200);
    step(10);
    check("a_nbeats", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++)
      check("a_beat", {beats[i].we, beats[i].addr}, {1'b0, 32'h100 + 32'(4 * i)});
    check("a_npush", tx_got.size(), 2);
    for (int i = 0; i < 2 && i < tx_got.size(); i++)
      check("a_push", tx_got[i], {rd(32'h100 + 32'(8 * i)), rd(32'h104 + 32'(8 * i))});
    if (beats.size() != 0 && fill_cyc.size() != 0)
      check("a_latency", fill_cyc[0] - int'(beats[0].cyc), 2);
    check("a_hold", {tx_data_l, tx_data_r}, {32'hA1, 32'hB1});

    // linear rx, one frame
    clear_logs();
    rxq.push_back('{l: 32'h11, r: 32'h22});
    step(2);
    start_rx(32'h200, 16'd1, 1'b0);
    wait_flag("b_done", 1, 200);
    step(10);
    check("b_drains", drains, 1);
    check("b_nbeats", beats.size(), 2);
    if (beats.size() >= 2) begin
      check("b_wr_l", {beats[0].we, beats[0].addr, beats[0].data}, {1'b1, 32'h200, 32'h11});
      check("b_wr_r", {beats[1].we, beats[1].addr, beats[1].data}, {1'b1, 32'h204, 32'h22});
    end

    // both channels competing from reset: strict alternation starting with tx
    do_reset();
    max_wait = 2;
    for (int i = 0; i < 6; i++) mem[32'h1000 + 32'(4 * i)] = $urandom;
    push_rx(5);
    step(2);
    tx_base = 32'h1000; tx_len = 16'd3; tx_circ = 1'b0;
    rx_base = 32'h2000; rx_len = 16'd3; rx_circ = 1'b0;
    tx_start = 1'b1; rx_start = 1'b1;
    step(1);
    tx_start = 1'b0; rx_start = 1'b0;
    wait_flag("c_tx_done", 0, 400);
    wait_flag("c_rx_done", 1, 400);
    step(10);
    check("c_ngrants", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("c_grant", grants[i], i % 2);
    check("c_npush", tx_got.size(), 3);
    for (int i = 0; i < 3 && i < tx_got.size(); i++)
      check("c_push", tx_got[i], {rd(32'h1000 + 32'(8 * i)), rd(32'h1004 + 32'(8 * i))});
    for (int i = 0; i < 3; i++) begin
      check("c_rx_l", rd(32'h2000 + 32'(8 * i)), exp_rx[i].l);
      check("c_rx_r", rd(32'h2004 + 32'(8 * i)), exp_rx[i].r);
    end
    check("c_rx_left", rxq.size(), 2);

    // circular tx over two frames, stopped by FIFO full
    do_reset();
    max_wait = 1;
    for (int i = 0; i < 4; i++) mem[32'h40 + 32'(4 * i)] = $urandom;
    start_tx(32'h40, 16'd2, 1'b1);
    n = 0;
    while (n < 400 && tx_got.size() < 5) begin step(1); n++; end
    tx_full = 1'b1;
    step(20);
    n = tx_got.size();
    check("d_enough", n >= 5, 1);
    check("d_nbeats", beats.size(), 2 * n);
    for (int j = 0; j < beats.size(); j++)
      check("d_beat", beats[j].addr, 32'h40 + 32'(8 * ((j / 2) % 2)) + 32'(4 * (j % 2)));
    for (int i = 0; i < n; i++)
      check("d_push", tx_got[i], {rd(32'h40 + 32'(8 * (i % 2))), rd(32'h44 + 32'(8 * (i % 2)))});
    check("d_wraps", tx_wraps, n / 2);
    check("d_not_done", tx_done, 0);
    tx_full = 1'b0; tx_circ = 1'b0;
    do_reset();

    // right-channel read stalled five cycles
    max_wait = 0;
    wait_plan.push_back(0);
    wait_plan.push_back(5);
    mem[32'h100] = $urandom; mem[32'h104] = $urandom;
    start_tx(32'h100, 16'd1, 1'b0);
    n = 0;
    while (n < 50 && !(mem_req && mem_addr == 32'h104)) begin step(1); n++; end
    for (int i = 0; i < 5; i++) begin
      check("e_stall", {mem_req, mem_addr, tx_data_fill, mem_ack}, {1'b1, 32'h104, 1'b0, 1'b0});
      step(1);
    end
    wait_flag("e_done", 0, 100);
    check("e_npush", tx_got.size(), 1);
    if (tx_got.size() != 0) check("e_push", tx_got[0], {rd(32'h100), rd(32'h104)});

    // reset while a write beat is stalled
    clear_logs();
    wait_plan.push_back(3);
    push_rx(2);
    step(2);
    start_rx(32'h300, 16'd1, 1'b0);
    n = 0;
    while (n < 50 && !(mem_req && mem_we)) begin step(1); n++; end
    check("f_in_write", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h300});
    rstn = 1'b0;
    #1;
    check("f_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, tx_data_fill, tx_data_l, tx_data_r,
                              rx_data_drain, tx_done, rx_done, tx_wrap, rx_wrap}, '0);
    step(2);
    rstn = 1'b1;
    clear_logs();
    step(20);
    check("f_no_req", beats.size(), 0);
    check("f_req_low", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iis_dma_ctrl.md
Name: iis_dma_ctrl

Overview:
- Memory-side sequencer for the I2S interface block: refills its tx L/R FIFOs from a memory buffer and empties its rx L/R FIFOs into a second memory buffer.
- Owns the single shared memory request port and arbitrates it round-robin between the tx and rx channels.
- Supports linear (stop at end) or circular (auto-wrap) buffers per channel.
- Sits between the system bus master and the I2S interface FIFO ports; runs entirely on clk.

Parameters:
AW, 32, memory address width
LW, 16, frame-count width for buffer lengths

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  1  global run enable
tx_start  in  1  one-cycle pulse: load tx_base/tx_len, clear tx_done
tx_circ  in  1  1 = tx buffer wraps to base at end
tx_base  in  AW  tx buffer byte address (8-byte aligned)
tx_len  in  LW  tx buffer length in stereo frames
rx_start  in  1  one-cycle pulse: load rx_base/rx_len, clear rx_done
rx_circ  in  1  1 = rx buffer wraps
rx_base  in  AW  rx buffer byte address (8-byte aligned)
rx_len  in  LW  rx buffer length in frames
tx_data_l_full  in  1  tx left FIFO full
tx_data_r_full  in  1  tx right FIFO full
tx_data_fill  out  1  one-cycle push into both tx FIFOs
tx_data_l  out  32  left sample to push
tx_data_r  out  32  right sample to push
rx_data_l_empty  in  1  rx left FIFO empty
rx_data_r_empty  in  1  rx right FIFO empty
rx_data_drain  out  1  one-cycle pop from both rx FIFOs
rx_data_l  in  32  rx left FIFO head
rx_data_r  in  32  rx right FIFO head
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  byte address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_req && mem_ack
mem_ack  in  1  beat completes in any cycle with mem_req && mem_ack
tx_done  out  1  sticky: linear tx buffer exhausted
rx_done  out  1  sticky: linear rx buffer filled
tx_wrap  out  1  one-cycle pulse on tx circular wrap
rx_wrap  out  1  one-cycle pulse on rx circular wrap

Behaviour:
- Reset values: all outputs 0; tx/rx remaining counts 0; address regs 0; FSM in IDLE; last_grant = rx.
- Start pulse: remaining <= len, addr <= base, done <= 0.
  - If the FSM is inside that channel's sequence, the start is held pending and applied on the next entry to IDLE.
  - len = 0: done set immediately (linear) or the channel stays idle (circular).
- Request conditions (evaluated only in IDLE, with enable = 1):
  - tx_need = remaining_tx != 0 && !tx_data_l_full && !tx_data_r_full
  - rx_need = remaining_rx != 0 && !rx_data_l_empty && !rx_data_r_empty
- Arbitration: if both need, grant the channel not in last_grant. last_grant updates on each grant.
- FSM states: IDLE, TX_RD_L, TX_RD_R, TX_PUSH, RX_POP, RX_WR_L, RX_WR_R, SETTLE.
  - TX_RD_L: read at addr; on ack, capture rdata into tx_data_l.
  - TX_RD_R: read at addr+4; on ack, capture into tx_data_r.
  - TX_PUSH: tx_data_fill = 1 for exactly one cycle; tx_data_l/r held stable until the next TX_RD_L.
  - RX_POP: capture rx_data_l/r into hold registers; rx_data_drain = 1 for one cycle.
  - RX_WR_L: write left hold register to addr.
  - RX_WR_R: write right hold register to addr+4.
  - SETTLE: one cycle so FIFO full/empty flags update before IDLE re-evaluates.
- mem_req, mem_we, mem_addr, mem_wdata stay stable from assertion until ack. mem_req never drops without ack. Back-to-back beats are allowed (req stays high into the next state).
- Frame completion (after TX_PUSH / RX_WR_R): addr += 8, remaining -= 1.
  - If remaining reaches 0 with circ = 1: addr <= base, remaining <= len, wrap pulse for one cycle.
  - If remaining reaches 0 with circ = 0: done <= 1.
  - base/len are re-sampled at wrap.
- Address arithmetic is modulo 2^AW; no bounds check.
- enable deasserted mid-sequence: the current beat completes, then the FSM goes to SETTLE then IDLE with the frame abandoned. Counters and addr are not advanced; the frame is retried later.
  - Exception: an rx frame already popped completes its writes anyway, so no data is lost.
- Minimum tx frame latency, IDLE grant to fill pulse: 4 cycles with zero-wait ack.

Test Plan:
- tx_start base=0x100, len=2, linear; mem returns 0xA0,0xB0,0xA1,0xB1 with immediate ack → reads at 0x100,0x104,0x108,0x10C; two fill pulses with (L,R)=(A0,B0),(A1,B1); tx_done=1; no further mem_req.
- rx: both FIFOs non-empty with L=0x11,R=0x22; rx_base=0x200, len=1 → one drain pulse, then writes 0x11@0x200 and 0x22@0x204; rx_done=1.
- tx and rx both needing continuously, tx_len=rx_len=3 → grants alternate tx,rx,tx,rx,tx,rx, starting with tx after reset.
- tx_circ=1, len=2, base=0x40 → addresses 0x40,0x48, then 0x40 again; tx_wrap pulses once per two frames; tx_done stays 0.
- mem_ack held low 5 cycles during TX_RD_R → mem_req/addr 0x104 stable all 5 cycles; tx_data_fill absent until ack.
- rstn asserted mid RX_WR_L → all outputs 0 immediately; after release, no mem_req until a new start.
